// File: rtl/perf_report_pkg.sv
// Shared types and constants for the performance report framer.
// Optional checksum word: PERF_REPORT_CHKSUM_EN adds an 8th word (XOR of w0..w6).
package perf_report_pkg;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A5_5AA5;

`ifdef PERF_REPORT_CHKSUM_EN
    localparam int NWORDS = 8;
`else
    localparam int NWORDS = 7;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [2:0] word_idx_t;

    localparam word_idx_t LAST_IDX = word_idx_t'(NWORDS - 1);

    typedef struct packed {
        logic [7:0]  warn;
        logic [7:0]  fifo_util;
        logic [31:0] throughput;
        logic [31:0] avg_lat;
        logic [31:0] max_lat;
        logic [15:0] trig_rate;
        logic [31:0] debug;
    } report_snapshot_t;

endpackage

// File: rtl/perf_period_timer.sv
// Periodic report tick. Counts up while enabled and fires once cnt reaches
// cfg_period-1; the ">=" compare lets a lowered period take effect at once.
module perf_period_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] cfg_period,
    output logic        tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Tick decode and next count; held at 0 whenever the timer is off.
    always_comb begin
        tick  = enable && (cfg_period != 32'd0) && (cnt_q >= cfg_period - 32'd1);
        cnt_d = cnt_q + 32'd1;
        if (!enable || (cfg_period == 32'd0) || tick) begin
            cnt_d = 32'd0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/perf_report_framer.sv
// Frames snapshots of performance metrics into fixed-length report packets
// on a stream master port, with sticky warnings and a maskable interrupt.
// Optional checksum word: PERF_REPORT_CHKSUM_EN.
//
// state | meaning
// IDLE  | no packet in flight; start one on a request or a pending request
// SEND  | streaming word[idx] of the latched snapshot
module perf_report_framer
    import perf_report_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int          SEQ_WIDTH = 16,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [31:0]          cfg_period,
    input  logic                 force_report,
    input  logic [31:0]          throughput_sps,
    input  logic [31:0]          avg_latency_ns,
    input  logic [31:0]          max_latency_ns,
    input  logic [7:0]           fifo_utilization_pct,
    input  logic [15:0]          trigger_rate_ppm,
    input  logic [7:0]           warning_flags,
    input  logic [31:0]          debug_counters,
    input  logic [7:0]           warn_clear,
    input  logic [7:0]           warn_irq_mask,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [7:0]           warn_sticky,
    output logic                 irq_warning,
    output logic [CNT_WIDTH-1:0] reports_sent,
    output logic [CNT_WIDTH-1:0] reports_coalesced
);

    state_t                 state_q, state_d;
    word_idx_t              idx_q, idx_d;
    report_snapshot_t       snap_q, snap_d;
    logic                   pending_q, pending_d;
    logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic [CNT_WIDTH-1:0]   coal_q, coal_d;
    logic [7:0]             warn_prev_q, warn_prev_d;
    logic [7:0]             sticky_q, sticky_d;
    logic                   irq_q, irq_d;

    logic                   period_tick;
    logic                   req;
    logic [31:0]            word [NWORDS];
    logic [31:0]            chksum;

    perf_period_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_period (cfg_period),
        .tick       (period_tick)
    );

    // Packet words built from the latched snapshot; seq only moves between packets.
    always_comb begin
        word[0] = SYNC_WORD;
        word[1] = {seq_q[15:0], snap_q.warn, snap_q.fifo_util};
        word[2] = snap_q.throughput;
        word[3] = snap_q.avg_lat;
        word[4] = snap_q.max_lat;
        word[5] = {snap_q.trig_rate, 16'h0000};
        word[6] = snap_q.debug;
        chksum  = word[0] ^ word[1] ^ word[2] ^ word[3] ^ word[4] ^ word[5] ^ word[6];
`ifdef PERF_REPORT_CHKSUM_EN
        word[7] = chksum;
`endif
    end

    // Request merge, framing FSM, counters and warning tracking.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        pending_d   = pending_q;
        seq_d       = seq_q;
        sent_d      = sent_q;
        coal_d      = coal_q;
        warn_prev_d = warning_flags;
        sticky_d    = (sticky_q & ~warn_clear) | warning_flags;
        irq_d       = |(sticky_q & warn_irq_mask);

        req = enable && (period_tick || force_report || ((warning_flags & ~warn_prev_q) != 8'h00));

        case (state_q)
            IDLE: begin
                if (enable && (req || pending_q)) begin
                    snap_d.warn       = warning_flags;
                    snap_d.fifo_util  = fifo_utilization_pct;
                    snap_d.throughput = throughput_sps;
                    snap_d.avg_lat    = avg_latency_ns;
                    snap_d.max_lat    = max_latency_ns;
                    snap_d.trig_rate  = trigger_rate_ppm;
                    snap_d.debug      = debug_counters;
                    pending_d         = 1'b0;
                    idx_d             = '0;
                    state_d           = SEND;
                end
            end
            SEND: begin
                if (req) begin
                    if (pending_q && (coal_q != {CNT_WIDTH{1'b1}})) begin
                        coal_d = coal_q + CNT_WIDTH'(1);
                    end
                    pending_d = 1'b1;
                end
                if (m_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        seq_d   = seq_q + SEQ_WIDTH'(1);
                        if (sent_q != {CNT_WIDTH{1'b1}}) begin
                            sent_d = sent_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        idx_d = idx_q + word_idx_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            pending_q   <= 1'b0;
            seq_q       <= '0;
            sent_q      <= '0;
            coal_q      <= '0;
            warn_prev_q <= 8'h00;
            sticky_q    <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            pending_q   <= pending_d;
            seq_q       <= seq_d;
            sent_q      <= sent_d;
            coal_q      <= coal_d;
            warn_prev_q <= warn_prev_d;
            sticky_q    <= sticky_d;
            irq_q       <= irq_d;
        end
    end

    // Stream outputs come straight from registers, so they hold under backpressure.
    always_comb begin
        m_tvalid          = (state_q == SEND);
        m_tlast           = (state_q == SEND) && (idx_q == LAST_IDX);
        m_tdata           = (state_q == SEND) ? word[idx_q] : 32'h0;
        warn_sticky       = sticky_q;
        irq_warning       = irq_q;
        reports_sent      = sent_q;
        reports_coalesced = coal_q;
    end

endmodule

// File: tb/tb_perf_report_framer.sv
// Self-checking bench for perf_report_framer: directed scenarios plus a
// randomized run compared against a packet-level reference model.
module tb_perf_report_framer;

`ifdef PERF_REPORT_CHKSUM_EN
    localparam int NW = 8;
`else
    localparam int NW = 7;
`endif
    localparam logic [31:0] SYNC = 32'hA5A5_5AA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] cfg_period;
    logic        force_report;
    logic [31:0] throughput_sps, avg_latency_ns, max_latency_ns, debug_counters;
    logic [7:0]  fifo_utilization_pct, warning_flags, warn_clear, warn_irq_mask;
    logic [15:0] trigger_rate_ppm;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [7:0]  warn_sticky;
    logic        irq_warning;
    logic [15:0] reports_sent, reports_coalesced;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: packet in flight as a list of words plus bookkeeping.
    bit          md_active;
    int          md_word;
    logic [31:0] md_pkt [8];
    logic [15:0] md_seq;
    bit          md_pend;
    int          md_sent, md_coal;
    logic [7:0]  md_sticky, md_prev;
    bit          md_irq;
    logic [31:0] md_cnt;

    always #5 clk = ~clk;

    perf_report_framer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .cfg_period           (cfg_period),
        .force_report         (force_report),
        .throughput_sps       (throughput_sps),
        .avg_latency_ns       (avg_latency_ns),
        .max_latency_ns       (max_latency_ns),
        .fifo_utilization_pct (fifo_utilization_pct),
        .trigger_rate_ppm     (trigger_rate_ppm),
        .warning_flags        (warning_flags),
        .debug_counters       (debug_counters),
        .warn_clear           (warn_clear),
        .warn_irq_mask        (warn_irq_mask),
        .m_tdata              (m_tdata),
        .m_tvalid             (m_tvalid),
        .m_tready             (m_tready),
        .m_tlast              (m_tlast),
        .warn_sticky          (warn_sticky),
        .irq_warning          (irq_warning),
        .reports_sent         (reports_sent),
        .reports_coalesced    (reports_coalesced)
    );

    task automatic build_pkt();
        md_pkt[0] = SYNC;
        md_pkt[1] = {md_seq, warning_flags, fifo_utilization_pct};
        md_pkt[2] = throughput_sps;
        md_pkt[3] = avg_latency_ns;
        md_pkt[4] = max_latency_ns;
        md_pkt[5] = {trigger_rate_ppm, 16'h0000};
        md_pkt[6] = debug_counters;
        md_pkt[7] = 32'h0;
        for (int i = 0; i < 7; i++) md_pkt[7] = md_pkt[7] ^ md_pkt[i];
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit         tick_m, req_m;
        logic [7:0] rise_m;
        if (!rst_n) begin
            md_active = 0; md_word = 0; md_seq = '0; md_pend = 0;
            md_sent = 0; md_coal = 0; md_sticky = '0; md_prev = '0;
            md_irq = 0; md_cnt = '0;
            return;
        end
        tick_m = enable && (cfg_period != 0) && (md_cnt >= cfg_period - 32'd1);
        if (!enable || cfg_period == 0 || tick_m) md_cnt = '0;
        else md_cnt = md_cnt + 32'd1;
        rise_m = warning_flags & ~md_prev;
        req_m  = enable && (tick_m || force_report || rise_m != 0);
        if (!md_active) begin
            if (enable && (req_m || md_pend)) begin
                build_pkt();
                md_pend = 0; md_word = 0; md_active = 1;
            end
        end else begin
            if (req_m) begin
                if (md_pend && md_coal < 65535) md_coal++;
                md_pend = 1;
            end
            if (m_tready) begin
                if (md_word == NW - 1) begin
                    md_active = 0;
                    md_seq    = md_seq + 16'd1;
                    if (md_sent < 65535) md_sent++;
                end else begin
                    md_word++;
                end
            end
        end
        md_irq    = |(md_sticky & warn_irq_mask);
        md_sticky = (md_sticky & ~warn_clear) | warning_flags;
        md_prev   = warning_flags;
    endtask

    // Inputs change only at the falling edge; the model steps alongside the DUT edge.
    task automatic tick_clk();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 0; cfg_period = 0; force_report = 0; m_tready = 0;
        warning_flags = 0; warn_clear = 0; warn_irq_mask = 0;
        throughput_sps = 32'h1111_0001; avg_latency_ns = 32'h2222_0002;
        max_latency_ns = 32'h3333_0003; fifo_utilization_pct = 8'h44;
        trigger_rate_ppm = 16'h5555; debug_counters = 32'h6666_0006;
        tick_clk();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 0;
        tick_clk();
        n_checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== 34'h0)
            $display("FAIL reset_stream: got valid=%b last=%b data=%h expected all 0", m_tvalid, m_tlast, m_tdata);
        else n_pass++;
        n_checks++;
        if ({warn_sticky, irq_warning, reports_sent, reports_coalesced} !== 41'h0)
            $display("FAIL reset_status: got sticky=%h irq=%b sent=%0d coal=%0d expected all 0",
                     warn_sticky, irq_warning, reports_sent, reports_coalesced);
        else n_pass++;
        rst_n = 1;
    endtask

    task automatic test_periodic();
        int k = 0, npk = 0;
        int starts [3];
        logic [15:0] seqs [3];
        bit prev_v = 0;
        do_reset();
        enable = 1; cfg_period = 100; m_tready = 1;
        for (int c = 0; c < 320; c++) begin
            if (m_tvalid && !prev_v) begin
                if (npk < 3) starts[npk] = c;
                npk++;
                k = 0;
            end
            if (m_tvalid && m_tready) begin
                if (k == 0) begin
                    n_checks++;
                    if (m_tdata !== SYNC) $display("FAIL periodic_w0: got %h expected %h", m_tdata, SYNC);
                    else n_pass++;
                end
                if (k == 1 && npk <= 3) seqs[npk-1] = m_tdata[31:16];
                n_checks++;
                if (m_tlast !== (k == NW - 1))
                    $display("FAIL periodic_tlast: got %b expected %b at word %0d", m_tlast, (k == NW - 1), k);
                else n_pass++;
                k++;
            end
            prev_v = m_tvalid;
            tick_clk();
        end
        n_checks++;
        if (npk != 3) $display("FAIL periodic_count: got %0d packets expected 3", npk);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (starts[i] != 100 * (i + 1))
                    $display("FAIL periodic_start: got cycle %0d expected %0d", starts[i], 100 * (i + 1));
                else n_pass++;
                n_checks++;
                if (seqs[i] !== 16'(i)) $display("FAIL periodic_seq: got %0d expected %0d", seqs[i], i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        bit done = 0;
        do_reset();
        enable = 1; m_tready = 0; force_report = 1;
        tick_clk();
        force_report = 0;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== SYNC)
            $display("FAIL bp_first: got valid=%b data=%h expected 1/%h", m_tvalid, m_tdata, SYNC);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== SYNC)
                $display("FAIL bp_hold: got valid=%b data=%h expected 1/%h", m_tvalid, m_tdata, SYNC);
            else n_pass++;
        end
        m_tready = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (m_tvalid) begin
                n_checks++;
                if (m_tdata !== md_pkt[k] || m_tlast !== (k == NW - 1))
                    $display("FAIL bp_word: got %h/%b expected %h/%b at word %0d",
                             m_tdata, m_tlast, md_pkt[k], (k == NW - 1), k);
                else n_pass++;
                if (m_tlast) done = 1;
                k++;
            end
            tick_clk();
        end
        n_checks++;
        if (!done || k != NW || reports_sent !== 16'd1)
            $display("FAIL bp_complete: got words=%0d sent=%0d expected %0d/1", k, reports_sent, NW);
        else n_pass++;
    endtask

    task automatic test_coalesce();
        int nstart = 0;
        bit prev_v = 1;
        do_reset();
        enable = 1; m_tready = 0; force_report = 1;
        tick_clk();
        force_report = 0; warning_flags = 8'h04;
        tick_clk();
        force_report = 1;
        tick_clk();
        force_report = 0; warning_flags = 8'h00;
        tick_clk();
        warning_flags = 8'h04;
        tick_clk();
        n_checks++;
        if (reports_coalesced !== 16'd2) $display("FAIL coal_count: got %0d expected 2", reports_coalesced);
        else n_pass++;
        m_tready = 1;
        for (int i = 0; i < 40; i++) begin
            if (m_tvalid && !prev_v) nstart++;
            prev_v = m_tvalid;
            tick_clk();
        end
        n_checks++;
        if (nstart != 1 || reports_sent !== 16'd2 || reports_coalesced !== 16'd2)
            $display("FAIL coal_followup: got starts=%0d sent=%0d coal=%0d expected 1/2/2",
                     nstart, reports_sent, reports_coalesced);
        else n_pass++;
    endtask

    task automatic test_sticky();
        do_reset();
        warn_irq_mask = 8'h08; warning_flags = 8'h08;
        tick_clk();
        warning_flags = 8'h00;
        n_checks++;
        if (warn_sticky !== 8'h08 || irq_warning !== 1'b0)
            $display("FAIL sticky_set: got %h/%b expected 08/0", warn_sticky, irq_warning);
        else n_pass++;
        tick_clk();
        n_checks++;
        if (warn_sticky !== 8'h08 || irq_warning !== 1'b1)
            $display("FAIL sticky_irq: got %h/%b expected 08/1", warn_sticky, irq_warning);
        else n_pass++;
        warn_clear = 8'h08;
        tick_clk();
        warn_clear = 8'h00;
        n_checks++;
        if (warn_sticky !== 8'h00 || irq_warning !== 1'b1)
            $display("FAIL sticky_clear: got %h/%b expected 00/1", warn_sticky, irq_warning);
        else n_pass++;
        tick_clk();
        n_checks++;
        if (irq_warning !== 1'b0) $display("FAIL sticky_irq_drop: got %b expected 0", irq_warning);
        else n_pass++;
        warning_flags = 8'h08; warn_clear = 8'h08;
        tick_clk();
        warning_flags = 8'h00; warn_clear = 8'h00;
        n_checks++;
        if (warn_sticky !== 8'h08) $display("FAIL sticky_set_wins: got %h expected 08", warn_sticky);
        else n_pass++;
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        enable = 1; m_tready = 1; avg_latency_ns = 32'h1234_5678; force_report = 1;
        tick_clk();
        force_report = 0;
        for (int i = 0; i < 12; i++) tick_clk();
        force_report = 1;
        tick_clk();
        force_report = 0;
        for (int i = 0; i < 3; i++) tick_clk();
        n_checks++;
        if (m_tdata !== 32'h1234_5678 || reports_sent !== 16'd1)
            $display("FAIL midpkt_w3: got %h sent=%0d expected 12345678 sent=1", m_tdata, reports_sent);
        else n_pass++;
        rst_n = 0;
        tick_clk();
        rst_n = 1;
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || reports_sent !== 16'd0 || reports_coalesced !== 16'd0)
            $display("FAIL midpkt_reset: got valid=%b last=%b sent=%0d coal=%0d expected 0/0/0/0",
                     m_tvalid, m_tlast, reports_sent, reports_coalesced);
        else n_pass++;
        enable = 1; force_report = 1;
        tick_clk();
        force_report = 0;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== SYNC)
            $display("FAIL midpkt_restart: got %b/%h expected 1/%h", m_tvalid, m_tdata, SYNC);
        else n_pass++;
        n_checks++;
        tick_clk();
        if (m_tdata[31:16] !== 16'h0000) $display("FAIL midpkt_seq: got %h expected 0000", m_tdata[31:16]);
        else n_pass++;
    endtask

    task automatic test_random();
        int fails = 0;
        logic [31:0] exp_d;
        do_reset();
        enable = 1; cfg_period = 17; warn_irq_mask = 8'h5A;
        for (int c = 0; c < 4000 && fails < 50; c++) begin
            exp_d = md_active ? md_pkt[md_word] : 32'h0;
            n_checks++;
            if (m_tvalid !== md_active || m_tdata !== exp_d || m_tlast !== (md_active && md_word == NW - 1)) begin
                $display("FAIL rand_stream: cycle %0d got %b/%h/%b expected %b/%h/%b", c, m_tvalid, m_tdata,
                         m_tlast, md_active, exp_d, (md_active && md_word == NW - 1));
                fails++;
            end else n_pass++;
            n_checks++;
            if (warn_sticky !== md_sticky || irq_warning !== md_irq ||
                reports_sent !== 16'(md_sent) || reports_coalesced !== 16'(md_coal)) begin
                $display("FAIL rand_status: cycle %0d got %h/%b/%0d/%0d expected %h/%b/%0d/%0d", c, warn_sticky,
                         irq_warning, reports_sent, reports_coalesced, md_sticky, md_irq, md_sent, md_coal);
                fails++;
            end else n_pass++;
            rst_n                = ($urandom_range(999) >= 3);
            if ($urandom_range(99) == 0) enable = ~enable;
            if ($urandom_range(99) == 0) cfg_period = $urandom_range(60);
            force_report         = ($urandom_range(99) < 5);
            m_tready             = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) warning_flags = 8'($urandom);
            warn_clear           = ($urandom_range(99) < 5) ? 8'($urandom) : 8'h00;
            if ($urandom_range(199) == 0) warn_irq_mask = 8'($urandom);
            throughput_sps       = $urandom;
            avg_latency_ns       = $urandom;
            max_latency_ns       = $urandom;
            debug_counters       = $urandom;
            fifo_utilization_pct = 8'($urandom);
            trigger_rate_ppm     = 16'($urandom);
            tick_clk();
        end
    endtask

    initial begin
        rst_n = 0;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_backpressure();
        test_coalesce();
        test_sticky();
        test_reset_midpacket();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
